// File: rtl/fdam_rob_pkg.sv
// -----------------------------------------------------------------------------
// fdam_rob_pkg
//   Shared types and helpers for the read-response reorder buffer (ROB) that
//   sits between buffer_controller and the CCI-P c0 read channel.
//
//   Contents
//     ROB_* constants : default geometry (128-entry ROB, 512-bit lines,
//                       42-bit line addresses, 16-bit mdata)
//     t_rob_tag       : ROB slot index
//     t_rob_ptr       : slot index plus a wrap bit, so full and empty differ
//     t_rob_out       : one in-order response beat (line data + caller mdata)
//     in_window()     : true when a tag names a slot that is currently issued
//                       and not yet drained
// -----------------------------------------------------------------------------
package fdam_rob_pkg;

  localparam int unsigned ROB_TAG_BITS = 7;
  localparam int unsigned ROB_DEPTH    = 1 << ROB_TAG_BITS;
  localparam int unsigned ROB_DATA_W   = 512;
  localparam int unsigned ROB_ADDR_W   = 42;
  localparam int unsigned ROB_MDATA_W  = 16;

  typedef logic [ROB_TAG_BITS-1:0] t_rob_tag;
  typedef logic [ROB_TAG_BITS:0]   t_rob_ptr;

  typedef struct packed {
    logic [ROB_DATA_W-1:0]  data;
    logic [ROB_MDATA_W-1:0] mdata;
  } t_rob_out;

  // A tag is live when its distance from the head (modulo the ROB depth) is
  // smaller than the number of slots in flight. When the ROB is full the
  // count equals the depth, so every tag is live; when it is empty none are.
  function automatic logic in_window(input t_rob_tag tag,
                                     input t_rob_ptr rd_ptr,
                                     input t_rob_ptr wr_ptr);
    t_rob_ptr count;
    t_rob_tag offset;
    count  = wr_ptr - rd_ptr;
    offset = tag - rd_ptr[ROB_TAG_BITS-1:0];
    return ({1'b0, offset} < count);
  endfunction

endpackage

// File: rtl/rob_sdp_ram.sv
// -----------------------------------------------------------------------------
// rob_sdp_ram
//   Simple dual-port RAM: one synchronous write port and one read port whose
//   output is registered. The read register only updates when re=1, so it
//   doubles as a hold register for downstream back-pressure.
//
//   Ports
//     clk    in   1       clock
//     rst    in   1       asynchronous, active-low reset (read register only)
//     we     in   1       write enable
//     waddr  in   AW      write address
//     wdata  in   WIDTH   write data
//     re     in   1       read enable; loads rdata from mem[raddr]
//     raddr  in   AW      read address
//     rdata  out  WIDTH   registered read data
// -----------------------------------------------------------------------------
module rob_sdp_ram #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 128,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the storage array has no reset; a reset term would turn it into
  // flops instead of a RAM. Its contents only become visible through valid
  // tracking held elsewhere, so stale data is never observed.
  always_ff @(posedge clk) begin
    if (we) begin
      // NOTE: non-blocking assignment for all clocked state, so every
      // process sees the pre-edge values regardless of evaluation order.
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/rd_resp_reorder.sv
// -----------------------------------------------------------------------------
// rd_resp_reorder
//   Read-path stage between buffer_controller and fiu.c0 (CCI-P). Each read
//   request is tagged with the next sequential ROB slot; the caller's mdata is
//   parked in that slot and the slot number goes out as the c0Tx mdata. Read
//   responses come back in any order, land in the data RAM and set the slot's
//   valid bit. The head slot drains into the output register as soon as it is
//   valid, so buffer_controller sees line data in request order together with
//   its own mdata.
//
//   The ROB typedefs come from fdam_rob_pkg; the parameters must keep the
//   package geometry (their defaults).
//
//   Ports
//     clk            in   1           clock
//     rst            in   1           asynchronous, active-low reset
//     req_en         in   1           read request (legal when req_available)
//     req_addr       in   ADDR_W      line address
//     req_mdata      in   MDATA_W     caller tag, returned with the data
//     req_available  out  1           ROB not full and c0Tx not almost full
//     fiu_rd_en      out  1           registered c0Tx read request
//     fiu_rd_addr    out  ADDR_W      registered line address
//     fiu_rd_mdata   out  MDATA_W     ROB slot, zero-extended
//     fiu_almfull    in   1           c0TxAlmFull
//     resp_valid     in   1           c0Rx read response valid
//     resp_mdata     in   MDATA_W     returned ROB slot
//     resp_data      in   DATA_W      returned line
//     out_valid      out  1           in-order response valid
//     out_ready      in   1           consumer ready
//     out_data       out  DATA_W      line data
//     out_mdata      out  MDATA_W     caller mdata of that request
//     outstanding    out  TAG_BITS+1  issued minus drained
//     err_sticky     out  1           illegal request or bad response seen
// -----------------------------------------------------------------------------
module rd_resp_reorder
  import fdam_rob_pkg::*;
#(
  parameter int unsigned TAG_BITS = ROB_TAG_BITS,
  parameter int unsigned DATA_W   = ROB_DATA_W,
  parameter int unsigned ADDR_W   = ROB_ADDR_W,
  parameter int unsigned MDATA_W  = ROB_MDATA_W
) (
  input  logic                clk,
  input  logic                rst,
  // caller request side
  input  logic                req_en,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [MDATA_W-1:0]  req_mdata,
  output logic                req_available,
  // c0Tx
  output logic                fiu_rd_en,
  output logic [ADDR_W-1:0]   fiu_rd_addr,
  output logic [MDATA_W-1:0]  fiu_rd_mdata,
  input  logic                fiu_almfull,
  // c0Rx
  input  logic                resp_valid,
  input  logic [MDATA_W-1:0]  resp_mdata,
  input  logic [DATA_W-1:0]   resp_data,
  // in-order output
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [MDATA_W-1:0]  out_mdata,
  // status
  output logic [TAG_BITS:0]   outstanding,
  output logic                err_sticky
);

  // ---------------------------------------------------------------------------
  // Pointers and occupancy
  // ---------------------------------------------------------------------------
  t_rob_ptr wr_ptr;
  t_rob_ptr rd_ptr;
  t_rob_ptr count;
  t_rob_tag wr_tag;
  t_rob_tag rd_tag;
  logic     full;

  assign count  = wr_ptr - rd_ptr;
  assign full   = (count == t_rob_ptr'(ROB_DEPTH));
  assign wr_tag = wr_ptr[TAG_BITS-1:0];
  assign rd_tag = rd_ptr[TAG_BITS-1:0];

  // Purely from registered state plus fiu_almfull: a slot freed by a drain
  // this cycle only shows up here after rd_ptr has moved.
  assign req_available = ~full & ~fiu_almfull;
  assign outstanding   = count;

  // ---------------------------------------------------------------------------
  // Per-cycle decode
  // ---------------------------------------------------------------------------
  logic [ROB_DEPTH-1:0] vld;
  t_rob_tag             resp_tag;
  logic                 resp_hi_zero;
  logic                 issue;
  logic                 req_drop;
  logic                 resp_accept;
  logic                 resp_drop;
  logic                 out_load;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    issue        = 1'b0;
    req_drop     = 1'b0;
    resp_accept  = 1'b0;
    resp_drop    = 1'b0;
    out_load     = 1'b0;
    resp_tag     = resp_mdata[TAG_BITS-1:0];
    resp_hi_zero = (resp_mdata[MDATA_W-1:TAG_BITS] == '0);

    if (req_en) begin
      issue    = req_available;
      req_drop = ~req_available;
    end

    // A response is only trusted if it names a live slot that has not yet
    // been filled; anything else (stale, duplicate, foreign mdata) is dropped.
    if (resp_valid) begin
      resp_accept = resp_hi_zero & in_window(resp_tag, rd_ptr, wr_ptr) & ~vld[resp_tag];
      resp_drop   = ~resp_accept;
    end

    // The output register is the read register of both RAMs; it reloads when
    // it is empty or being consumed and the head slot holds data.
    out_load = (~out_valid | out_ready) & vld[rd_tag];
  end

  // ---------------------------------------------------------------------------
  // Storage: line data is written by responses, caller mdata by requests.
  // A write and a read never hit the same slot in one cycle: a write needs
  // vld=0 (response) or an empty ROB (request), while a read needs vld=1.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0]  data_q;
  logic [MDATA_W-1:0] mdata_q;
  t_rob_out           out_q;

  rob_sdp_ram #(
    .WIDTH (DATA_W),
    .DEPTH (ROB_DEPTH)
  ) u_data_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (resp_accept),
    .waddr (resp_tag),
    .wdata (resp_data),
    .re    (out_load),
    .raddr (rd_tag),
    .rdata (data_q)
  );

  rob_sdp_ram #(
    .WIDTH (MDATA_W),
    .DEPTH (ROB_DEPTH)
  ) u_mdata_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (issue),
    .waddr (wr_tag),
    .wdata (req_mdata),
    .re    (out_load),
    .raddr (rd_tag),
    .rdata (mdata_q)
  );

  assign out_q     = '{data: data_q, mdata: mdata_q};
  assign out_data  = out_q.data;
  assign out_mdata = out_q.mdata;

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      vld          <= '0;
      fiu_rd_en    <= 1'b0;
      fiu_rd_addr  <= '0;
      fiu_rd_mdata <= '0;
      out_valid    <= 1'b0;
      err_sticky   <= 1'b0;
    end else begin
      // Request issue: the c0Tx request leaves one cycle after acceptance.
      fiu_rd_en <= issue;
      if (issue) begin
        wr_ptr       <= wr_ptr + t_rob_ptr'(1);
        fiu_rd_addr  <= req_addr;
        fiu_rd_mdata <= MDATA_W'(wr_tag);
      end

      // Set and clear can coexist: set needs vld=0 and clear needs vld=1,
      // so they always address different slots.
      if (resp_accept) begin
        vld[resp_tag] <= 1'b1;
      end
      if (out_load) begin
        vld[rd_tag] <= 1'b0;
        rd_ptr      <= rd_ptr + t_rob_ptr'(1);
      end

      if (out_load) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (req_drop || resp_drop) begin
        err_sticky <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rd_resp_reorder.sv
// -----------------------------------------------------------------------------
// tb_rd_resp_reorder
//   Directed scenarios for the read-response reorder buffer. Inputs change
//   1 ns after the rising edge and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_rd_resp_reorder;

  localparam int TB_TAG = 7;
  localparam int DW     = 512;
  localparam int AW     = 42;
  localparam int MW     = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_en;
  logic [AW-1:0]     req_addr;
  logic [MW-1:0]     req_mdata;
  logic              req_available;
  logic              fiu_rd_en;
  logic [AW-1:0]     fiu_rd_addr;
  logic [MW-1:0]     fiu_rd_mdata;
  logic              fiu_almfull;
  logic              resp_valid;
  logic [MW-1:0]     resp_mdata;
  logic [DW-1:0]     resp_data;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic [MW-1:0]     out_mdata;
  logic [TB_TAG:0]   outstanding;
  logic              err_sticky;

  int n_checks = 0;
  int n_fail   = 0;

  logic [MW-1:0] got_mdata [$];
  logic [DW-1:0] got_data  [$];

  always #5 clk = ~clk;

  rd_resp_reorder dut (
    .clk           (clk),
    .rst           (rst),
    .req_en        (req_en),
    .req_addr      (req_addr),
    .req_mdata     (req_mdata),
    .req_available (req_available),
    .fiu_rd_en     (fiu_rd_en),
    .fiu_rd_addr   (fiu_rd_addr),
    .fiu_rd_mdata  (fiu_rd_mdata),
    .fiu_almfull   (fiu_almfull),
    .resp_valid    (resp_valid),
    .resp_mdata    (resp_mdata),
    .resp_data     (resp_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_mdata     (out_mdata),
    .outstanding   (outstanding),
    .err_sticky    (err_sticky)
  );

  // Distinct line pattern per sequence number; every 32-bit word differs.
  function automatic logic [DW-1:0] mk_data(input int s);
    logic [DW-1:0] r;
    logic [31:0]   w;
    w = 32'hDA7A_0000 ^ 32'(s);
    for (int k = 0; k < 16; k++) r[k*32 +: 32] = w + 32'(k * 32'h0101_0000);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_en      = 1'b0;
    req_addr    = '0;
    req_mdata   = '0;
    fiu_almfull = 1'b0;
    resp_valid  = 1'b0;
    resp_mdata  = '0;
    resp_data   = '0;
    out_ready   = 1'b0;
    rst         = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic issue(input logic [MW-1:0] md, input logic [AW-1:0] addr);
    req_en    = 1'b1;
    req_addr  = addr;
    req_mdata = md;
    tick();
    req_en = 1'b0;
  endtask

  task automatic respond(input logic [MW-1:0] md, input logic [DW-1:0] d);
    resp_valid = 1'b1;
    resp_mdata = md;
    resp_data  = d;
    tick();
    resp_valid = 1'b0;
  endtask

  // Gathers up to n beats with out_ready held high; gives up after max_cyc.
  task automatic collect(input int n, input int max_cyc);
    got_mdata.delete();
    got_data.delete();
    out_ready = 1'b1;
    for (int c = 0; c < max_cyc && got_mdata.size() < n; c++) begin
      if (out_valid) begin
        got_mdata.push_back(out_mdata);
        got_data.push_back(out_data);
      end
      tick();
    end
    out_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    req_en = 1'b0; fiu_almfull = 1'b0; resp_valid = 1'b0; out_ready = 1'b0;
    req_addr = '0; req_mdata = '0; resp_mdata = '0; resp_data = '0;
    rst = 1'b0;
    #3;
    n_checks++;
    if ({fiu_rd_en, out_valid, err_sticky, outstanding} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_flags: en/valid/err/outstanding = %b %b %b %0d, expected all 0",
               fiu_rd_en, out_valid, err_sticky, outstanding);
    end
    n_checks++;
    if (fiu_rd_addr !== '0 || fiu_rd_mdata !== '0) begin
      n_fail++;
      $display("FAIL reset_fiu: addr %h mdata %h, expected 0 0", fiu_rd_addr, fiu_rd_mdata);
    end
    n_checks++;
    if (out_data !== '0 || out_mdata !== '0) begin
      n_fail++;
      $display("FAIL reset_out: data %h mdata %h, expected 0", out_data, out_mdata);
    end
    n_checks++;
    if (req_available !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_available: got %b, expected 1", req_available);
    end
    rst = 1'b1;
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reorder();
    int order [4] = '{3, 1, 0, 2};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_en    = 1'b1;
      req_addr  = AW'(42'h100 + i);
      req_mdata = MW'(16'hA0 + i);
      tick();
      n_checks++;
      if (fiu_rd_en !== 1'b1 || fiu_rd_addr !== AW'(42'h100 + i) || fiu_rd_mdata !== MW'(i)) begin
        n_fail++;
        $display("FAIL issue_%0d: en %b addr %h tag %h, expected 1 %h %h",
                 i, fiu_rd_en, fiu_rd_addr, fiu_rd_mdata, AW'(42'h100 + i), MW'(i));
      end
    end
    req_en = 1'b0;
    tick();
    n_checks++;
    if (fiu_rd_en !== 1'b0 || outstanding !== 8'd4) begin
      n_fail++;
      $display("FAIL issue_idle: en %b outstanding %0d, expected 0 4", fiu_rd_en, outstanding);
    end
    for (int i = 0; i < 4; i++) respond(MW'(order[i]), mk_data(100 + order[i]));
    collect(4, 20);
    n_checks++;
    if (got_mdata.size() != 4) begin
      n_fail++;
      $display("FAIL reorder_count: got %0d beats, expected 4", got_mdata.size());
    end
    for (int k = 0; k < got_mdata.size() && k < 4; k++) begin
      n_checks++;
      if (got_mdata[k] !== MW'(16'hA0 + k) || got_data[k] !== mk_data(100 + k)) begin
        n_fail++;
        $display("FAIL reorder_beat_%0d: mdata %h data %h, expected %h %h",
                 k, got_mdata[k], got_data[k], MW'(16'hA0 + k), mk_data(100 + k));
      end
    end
    n_checks++;
    if (outstanding !== 8'd0 || out_valid !== 1'b0 || err_sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL reorder_end: outstanding %0d valid %b err %b, expected 0 0 0",
               outstanding, out_valid, err_sticky);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_full();
    do_reset();
    for (int i = 0; i < 128; i++) issue(MW'(16'h2000 + i), AW'(42'h2000 + i));
    n_checks++;
    if (req_available !== 1'b0 || outstanding !== 8'd128) begin
      n_fail++;
      $display("FAIL full_state: available %b outstanding %0d, expected 0 128",
               req_available, outstanding);
    end
    // Illegal request while full: dropped, flagged.
    issue(16'hDEAD, 42'h0);
    n_checks++;
    if (outstanding !== 8'd128 || err_sticky !== 1'b1 || fiu_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL full_drop: outstanding %0d err %b en %b, expected 128 1 0",
               outstanding, err_sticky, fiu_rd_en);
    end
    out_ready = 1'b1;
    respond(16'h0000, mk_data(200));
    n_checks++;
    if (req_available !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL full_resp_cycle: available %b valid %b, expected 0 0", req_available, out_valid);
    end
    tick();
    n_checks++;
    if (req_available !== 1'b1 || outstanding !== 8'd127) begin
      n_fail++;
      $display("FAIL full_free: available %b outstanding %0d, expected 1 127",
               req_available, outstanding);
    end
    n_checks++;
    if (out_valid !== 1'b1 || out_mdata !== 16'h2000 || out_data !== mk_data(200)) begin
      n_fail++;
      $display("FAIL full_head_beat: valid %b mdata %h data %h, expected 1 2000 %h",
               out_valid, out_mdata, out_data, mk_data(200));
    end
    out_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 3; i++) issue(MW'(16'h3000 + i), AW'(42'h3000 + i));
    respond(16'd2, mk_data(302));
    respond(16'd0, mk_data(300));
    respond(16'd1, mk_data(301));
    repeat (2) tick();
    for (int c = 0; c < 10; c++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_mdata !== 16'h3000 || out_data !== mk_data(300)) begin
        n_fail++;
        $display("FAIL hold_cycle_%0d: valid %b mdata %h data %h, expected 1 3000 %h",
                 c, out_valid, out_mdata, out_data, mk_data(300));
      end
      tick();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_mdata !== MW'(16'h3000 + k) || out_data !== mk_data(300 + k)) begin
        n_fail++;
        $display("FAIL release_beat_%0d: valid %b mdata %h data %h, expected 1 %h %h",
                 k, out_valid, out_mdata, out_data, MW'(16'h3000 + k), mk_data(300 + k));
      end
      tick();
    end
    n_checks++;
    if (out_valid !== 1'b0 || outstanding !== 8'd0) begin
      n_fail++;
      $display("FAIL release_end: valid %b outstanding %0d, expected 0 0", out_valid, outstanding);
    end
    out_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_bad_resp();
    int good [7] = '{0, 1, 2, 3, 4, 6, 7};
    do_reset();
    for (int i = 0; i < 8; i++) issue(MW'(16'h4000 + i), AW'(42'h4000 + i));
    respond(16'd5, mk_data(405));
    n_checks++;
    if (err_sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL first_resp_err: err %b, expected 0", err_sticky);
    end
    respond(16'd5, mk_data(999));
    n_checks++;
    if (err_sticky !== 1'b1) begin
      n_fail++;
      $display("FAIL duplicate_err: err %b, expected 1", err_sticky);
    end
    respond(16'h0090, mk_data(998));
    respond(16'h0082, mk_data(997));
    for (int i = 0; i < 7; i++) respond(MW'(good[i]), mk_data(400 + good[i]));
    collect(8, 30);
    n_checks++;
    if (got_mdata.size() != 8) begin
      n_fail++;
      $display("FAIL bad_resp_count: got %0d beats, expected 8", got_mdata.size());
    end
    for (int k = 0; k < got_mdata.size() && k < 8; k++) begin
      n_checks++;
      if (got_mdata[k] !== MW'(16'h4000 + k) || got_data[k] !== mk_data(400 + k)) begin
        n_fail++;
        $display("FAIL bad_resp_beat_%0d: mdata %h data %h, expected %h %h",
                 k, got_mdata[k], got_data[k], MW'(16'h4000 + k), mk_data(400 + k));
      end
    end
    n_checks++;
    if (err_sticky !== 1'b1 || outstanding !== 8'd0) begin
      n_fail++;
      $display("FAIL bad_resp_end: err %b outstanding %0d, expected 1 0", err_sticky, outstanding);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_random();
    int pend [$];
    int issued = 0;
    int rx     = 0;
    int cyc    = 0;
    int idx;
    int s;
    do_reset();
    while (rx < 200 && cyc < 6000) begin
      out_ready = ($urandom_range(3) != 0);
      if (out_valid && out_ready) begin
        n_checks++;
        if (out_mdata !== MW'(16'h5000 + rx) || out_data !== mk_data(1000 + rx)) begin
          n_fail++;
          $display("FAIL random_beat_%0d: mdata %h data %h, expected %h %h",
                   rx, out_mdata, out_data, MW'(16'h5000 + rx), mk_data(1000 + rx));
        end
        rx++;
      end
      if (pend.size() > 0 && $urandom_range(1) == 1) begin
        idx = $urandom_range(pend.size() - 1);
        s   = pend[idx];
        pend.delete(idx);
        resp_valid = 1'b1;
        resp_mdata = MW'(s % 128);
        resp_data  = mk_data(1000 + s);
      end else begin
        resp_valid = 1'b0;
      end
      fiu_almfull = ($urandom_range(3) == 0);
      #1;
      if (issued < 200 && req_available && $urandom_range(9) < 7) begin
        req_en    = 1'b1;
        req_mdata = MW'(16'h5000 + issued);
        req_addr  = AW'(42'h5_0000 + issued);
        pend.push_back(issued);
        issued++;
      end else begin
        req_en = 1'b0;
      end
      tick();
      cyc++;
    end
    req_en = 1'b0; resp_valid = 1'b0; fiu_almfull = 1'b0; out_ready = 1'b0;
    n_checks++;
    if (rx != 200 || issued != 200) begin
      n_fail++;
      $display("FAIL random_progress: drained %0d issued %0d in %0d cycles, expected 200 200",
               rx, issued, cyc);
    end
    n_checks++;
    if (err_sticky !== 1'b0 || outstanding !== 8'd0) begin
      n_fail++;
      $display("FAIL random_end: err %b outstanding %0d, expected 0 0", err_sticky, outstanding);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_midop();
    logic saw_valid = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) issue(MW'(16'h6000 + i), AW'(42'h6000 + i));
    n_checks++;
    if (outstanding !== 8'd6) begin
      n_fail++;
      $display("FAIL midop_before: outstanding %0d, expected 6", outstanding);
    end
    rst = 1'b0;
    #2;
    n_checks++;
    if (outstanding !== 8'd0 || err_sticky !== 1'b0 || fiu_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL midop_async: outstanding %0d err %b en %b, expected 0 0 0",
               outstanding, err_sticky, fiu_rd_en);
    end
    tick();
    rst = 1'b1;
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      respond(MW'(i), mk_data(600 + i));
      if (out_valid) saw_valid = 1'b1;
    end
    repeat (4) begin
      tick();
      if (out_valid) saw_valid = 1'b1;
    end
    n_checks++;
    if (saw_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midop_no_output: out_valid seen %b, expected 0", saw_valid);
    end
    n_checks++;
    if (err_sticky !== 1'b1 || outstanding !== 8'd0) begin
      n_fail++;
      $display("FAIL midop_end: err %b outstanding %0d, expected 1 0", err_sticky, outstanding);
    end
    out_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_reorder();
    test_full();
    test_backpressure();
    test_bad_resp();
    test_random();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation exceeded 500000 ns");
    $fatal(1);
  end

endmodule
